seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter DIVIDEND_W, default 16: dividend and quotient width.
REQ-002 SHALL have parameter DIVISOR_W, default 8: divisor and remainder width, DIVISOR_W <= DIVIDEND_W.
REQ-003 SHALL provide port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL provide port start  input  1  request; sampled only when busy=0.
REQ-006 SHALL provide port dividend  input  DIVIDEND_W  unsigned numerator.
REQ-007 SHALL provide port divisor  input  DIVISOR_W  unsigned denominator.
REQ-008 SHALL provide port busy  output  1  high while iterations are in progress.
REQ-009 SHALL provide port done  output  1  one-cycle completion pulse.
REQ-010 SHALL provide port quotient  output  DIVIDEND_W  result, valid from done onward.
REQ-011 SHALL provide port remainder  output  DIVISOR_W  result, valid from done onward.
REQ-012 SHALL provide port div_by_zero  output  1  error flag; present only under REQ-027.

Function
REQ-013 SHALL implement unsigned radix-2 restoring division: quotient = dividend / divisor, remainder = dividend % divisor.
REQ-014 SHALL use FSM states IDLE, CALC, DONE: IDLE/DONE + start -> CALC; CALC after the last iteration -> DONE; DONE -> IDLE otherwise.
REQ-015 SHALL latch dividend and divisor at the edge sampling start (edge k); later operand changes SHALL NOT affect the result.
REQ-016 SHALL perform one iteration per edge k+1..k+DIVIDEND_W, using a DIVISOR_W+1-bit partial remainder and an iteration counter.
REQ-017 SHALL register quotient, remainder and done=1 at edge k+DIVIDEND_W; done SHALL fall at edge k+DIVIDEND_W+1.
REQ-018 SHALL hold busy=1 from edge k through edge k+DIVIDEND_W; busy=0 in IDLE and DONE.
REQ-019 SHALL ignore start while busy=1.
REQ-020 SHALL accept start in DONE, allowing back-to-back operations with no idle cycle.
REQ-021 SHALL hold quotient and remainder unchanged during CALC; update only at completion.
REQ-022 SHALL, for divisor=0 without REQ-027, run the full DIVIDEND_W iterations and yield quotient all-ones, remainder = dividend[DIVISOR_W-1:0].

Reset
REQ-023 SHALL, on rst=1 at any time including mid-CALC, immediately force state IDLE and abort any operation.
REQ-024 SHALL reset busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-025 SHALL NOT produce a done pulse for an operation aborted by reset.
REQ-026 SHALL accept start on the first rising edge after rst deasserts.

Configuration
REQ-027 SHALL, when SEQ_DIVIDER_DBZ_EN is defined, detect divisor=0 at start and go straight to DONE at edge k+1 with done=1, div_by_zero=1, quotient all-ones, remainder=dividend[DIVISOR_W-1:0]; div_by_zero SHALL hold until the next accepted start.
REQ-028 SHALL, when SEQ_DIVIDER_DBZ_EN is undefined, omit div_by_zero and the early exit, behaving per REQ-022.

Structure
REQ-029 SHALL place the FSM state typedef and default width constants in package seq_divider_pkg.
REQ-030 SHALL implement one restoring iteration (shift, compare, conditional subtract, quotient bit) as combinational sub-module div_step, instantiated once.

Verification
REQ-031 SHALL cover: start with 100/7 -> after 16 cycles done=1 for one cycle, quotient=14, remainder=2.
REQ-032 SHALL cover: 65535/255 then 5/9 back-to-back, start asserted in the DONE cycle -> 257 r 0, then 0 r 5, with no idle cycle between.
REQ-033 SHALL cover: 1000/3 started, operands changed and start re-pulsed mid-CALC -> second start ignored, result 333 r 1.
REQ-034 SHALL cover: divisor=0, dividend=0x1234 -> with macro: done at edge k+1, div_by_zero=1, 0xFFFF r 0x34; without macro: done at edge k+16, 0xFFFF r 0x34.
REQ-035 SHALL cover: rst pulsed at iteration 8 of 200/13 -> busy=0, outputs 0, no done; a following 200/13 yields 15 r 5.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and default widths for the sequential divider.
package seq_divider_pkg;

  localparam int unsigned DefDividendW = 16;
  localparam int unsigned DefDivisorW  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division iteration: shift in the next dividend bit,
// compare against the divisor and subtract when it fits.
module div_step #(
  parameter int unsigned DIVISOR_W = 8
) (
  input  logic [DIVISOR_W:0]   rem_i,
  input  logic                 bit_i,
  input  logic [DIVISOR_W-1:0] divisor_i,
  output logic [DIVISOR_W:0]   rem_o,
  output logic                 q_o
);

  logic [DIVISOR_W:0] shifted;
  logic [DIVISOR_W:0] divisor_ext;

  // The incoming remainder is always below the divisor, so its top bit can be dropped.
  always_comb begin
    shifted     = {rem_i[DIVISOR_W-1:0], bit_i};
    divisor_ext = {1'b0, divisor_i};
    q_o         = (shifted >= divisor_ext);
    rem_o       = q_o ? (shifted - divisor_ext) : shifted;
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Optional feature: define SEQ_DIVIDER_DBZ_EN to add the div_by_zero flag and
// a one-cycle early exit when the divisor is zero.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int unsigned DIVIDEND_W = DefDividendW,
  parameter int unsigned DIVISOR_W  = DefDivisorW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder
`ifdef SEQ_DIVIDER_DBZ_EN
  ,
  output logic                  div_by_zero
`endif
);

  localparam int unsigned CntW = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DIVIDEND_W - 1);

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DIVISOR_W:0]    rem_q, rem_d;
  // Holds the unconsumed dividend bits at the top and collects quotient bits at the bottom.
  logic [DIVIDEND_W-1:0] work_q, work_d;
  logic [DIVISOR_W-1:0]  dvsr_q, dvsr_d;
  logic [DIVIDEND_W-1:0] quo_q, quo_d;
  logic [DIVISOR_W-1:0]  rmd_q, rmd_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
`ifdef SEQ_DIVIDER_DBZ_EN
  logic                  dbz_q, dbz_d;
`endif

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;

  div_step #(
    .DIVISOR_W(DIVISOR_W)
  ) u_div_step (
    .rem_i    (rem_q),
    .bit_i    (work_q[DIVIDEND_W-1]),
    .divisor_i(dvsr_q),
    .rem_o    (step_rem),
    .q_o      (step_q)
  );

  // Next-state and registered-output logic for the IDLE/CALC/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    work_d  = work_q;
    dvsr_d  = dvsr_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef SEQ_DIVIDER_DBZ_EN
    dbz_d   = dbz_q;
`endif
    unique case (state_q)
      StIdle, StDone: begin
        busy_d  = 1'b0;
        state_d = StIdle;
        if (start) begin
          state_d = StCalc;
          busy_d  = 1'b1;
          cnt_d   = '0;
          rem_d   = '0;
          work_d  = dividend;
          dvsr_d  = divisor;
`ifdef SEQ_DIVIDER_DBZ_EN
          dbz_d   = 1'b0;
`endif
        end
      end
      StCalc: begin
`ifdef SEQ_DIVIDER_DBZ_EN
        if (dvsr_q == '0) begin
          // work_q still holds the untouched dividend here.
          state_d = StDone;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          dbz_d   = 1'b1;
          quo_d   = '1;
          rmd_d   = work_q[DIVISOR_W-1:0];
        end else
`endif
        begin
          rem_d  = step_rem;
          work_d = {work_q[DIVIDEND_W-2:0], step_q};
          cnt_d  = cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            cnt_d   = '0;
            quo_d   = {work_q[DIVIDEND_W-2:0], step_q};
            rmd_d   = step_rem[DIVISOR_W-1:0];
          end
        end
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      work_q  <= '0;
      dvsr_q  <= '0;
      quo_q   <= '0;
      rmd_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef SEQ_DIVIDER_DBZ_EN
      dbz_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      work_q  <= work_d;
      dvsr_q  <= dvsr_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef SEQ_DIVIDER_DBZ_EN
      dbz_q   <= dbz_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rmd_q;
`ifdef SEQ_DIVIDER_DBZ_EN
  assign div_by_zero = dbz_q;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed cases plus randomized operations
// compared against plain / and % arithmetic.
module tb_seq_divider;

`ifdef SEQ_DIVIDER_DBZ_EN
  localparam bit DbzEn = 1'b1;
`else
  localparam bit DbzEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [7:0]  divisor = '0;
  logic        busy, done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dbz;

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned prev_q = 0;
  int unsigned prev_r = 0;
  int unsigned prev_dbz = 0;

  always #5 clk = ~clk;

  seq_divider #(
    .DIVIDEND_W(16),
    .DIVISOR_W (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .remainder(remainder)
`ifdef SEQ_DIVIDER_DBZ_EN
    ,
    .div_by_zero(dbz)
`endif
  );

`ifndef SEQ_DIVIDER_DBZ_EN
  assign dbz = 1'b0;
`endif

  task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive a start request; returns just after the accepting edge.
  task automatic start_op(input int unsigned a, input int unsigned b);
    @(negedge clk);
    dividend = a[15:0];
    divisor  = b[7:0];
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("accept_busy", busy, 1);
    check_eq("accept_done", done, 0);
    check_eq("accept_dbz", dbz, 0);
    check_eq("accept_q_hold", quotient, prev_q);
  endtask

  // Step through the operation with a fixed expected latency; optionally disturb
  // the operand inputs and re-pulse start, which must all be ignored.
  task automatic wait_done(input int unsigned a, input int unsigned b, input bit garble);
    int unsigned lat;
    int unsigned exp_q;
    int unsigned exp_r;
    bit          zero;
    zero  = (b == 0);
    lat   = (DbzEn && zero) ? 1 : 16;
    exp_q = zero ? 32'hFFFF : a / b;
    exp_r = zero ? (a & 32'hFF) : a % b;
    for (int cyc = 1; cyc <= int'(lat); cyc++) begin
      @(negedge clk);
      if (garble) begin
        dividend = 16'($urandom);
        divisor  = 8'($urandom);
        start    = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
      #1;
      if (cyc < int'(lat)) begin
        check_eq("calc_busy", busy, 1);
        check_eq("calc_done", done, 0);
        check_eq("calc_q_hold", quotient, prev_q);
        check_eq("calc_r_hold", remainder, prev_r);
      end else begin
        check_eq("done_pulse", done, 1);
        check_eq("done_busy", busy, 0);
        check_eq("quotient", quotient, exp_q);
        check_eq("remainder", remainder, exp_r);
        check_eq("dbz_flag", dbz, (DbzEn && zero) ? 1 : 0);
      end
    end
    start    = 1'b0;
    prev_q   = exp_q;
    prev_r   = exp_r;
    prev_dbz = (DbzEn && zero) ? 1 : 0;
  endtask

  // One cycle with no request after completion: done falls, results and flag hold.
  task automatic idle_cycle();
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("idle_done", done, 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_q", quotient, prev_q);
    check_eq("idle_r", remainder, prev_r);
    check_eq("idle_dbz", dbz, prev_dbz);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_q"}, quotient, 0);
    check_eq({tag, "_r"}, remainder, 0);
    check_eq({tag, "_dbz"}, dbz, 0);
  endtask

  initial begin
    #1;
    check_reset_outputs("rst_init");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // 100 / 7
    start_op(100, 7);
    wait_done(100, 7, 1'b0);
    idle_cycle();

    // Back-to-back: 65535/255 then 5/9 started in the DONE cycle
    start_op(65535, 255);
    wait_done(65535, 255, 1'b0);
    start_op(5, 9);
    wait_done(5, 9, 1'b0);
    idle_cycle();

    // Operands changed and start re-pulsed mid-operation
    start_op(1000, 3);
    wait_done(1000, 3, 1'b1);
    idle_cycle();

    // Divide by zero
    start_op(16'h1234, 0);
    wait_done(16'h1234, 0, 1'b0);
    idle_cycle();
    idle_cycle();

    // Reset at iteration 8 of 200/13, then restart on the first edge after release
    start_op(200, 13);
    repeat (8) begin
      @(posedge clk);
      #1;
      check_eq("pre_rst_done", done, 0);
    end
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_hold");
    prev_q   = 0;
    prev_r   = 0;
    prev_dbz = 0;
    @(negedge clk);
    rst      = 1'b0;
    dividend = 16'd200;
    divisor  = 8'd13;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check_eq("post_rst_accept", busy, 1);
    check_eq("post_rst_done", done, 0);
    wait_done(200, 13, 1'b0);
    idle_cycle();

    // Randomized operations, some back-to-back, some disturbed, some by zero
    for (int i = 0; i < 24; i++) begin
      int unsigned a;
      int unsigned b;
      a = $urandom_range(0, 65535);
      b = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 255);
      start_op(a, b);
      wait_done(a, b, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_cycle();
    end
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
